// File: rtl/seg_scan_mux.sv
`timescale 1ns/1ps
// seg_scan_mux: scans DIGITS hex digits onto a multiplexed seven-segment display,
// with a dark gap between digits and a display snapshot taken once per frame.
module seg_scan_mux #(
    parameter int DIGITS             = 4,
    parameter int BLANK_CYCLES       = 8,
    parameter bit LEADING_ZERO_BLANK = 1'b1,
    localparam int IDX_W             = $clog2(DIGITS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                scan_clk,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an,
    output logic [IDX_W-1:0]    digit_idx,
    output logic                frame_done
);
    localparam logic [7:0]       BLANK_LAST = 8'((BLANK_CYCLES < 1) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    state_t              r_state, w_state_n;
    logic [IDX_W-1:0]    r_idx, w_idx_n;
    logic [7:0]          r_cnt, w_cnt_n;
    logic [4*DIGITS-1:0] r_snap_val, w_snap_val_n;
    logic [DIGITS-1:0]   r_snap_dp, w_snap_dp_n;
    logic [DIGITS-1:0]   r_an, w_an_n;
    logic [6:0]          r_seg, w_seg_n;
    logic                r_dp_n, w_dp_n_n;
    logic                r_frame, w_frame_n;
    logic                r_s1, r_s2, r_s3;
    logic                w_tick;

    function automatic logic [6:0] hex_decode(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Digit idx is a leading zero when it and every more-significant digit are zero.
    function automatic logic lz_blank(input logic [4*DIGITS-1:0] v, input logic [IDX_W-1:0] idx);
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j >= int'(idx) && v[4*j +: 4] != 4'h0) nz = 1'b1;
        end
        return (idx != '0) && !nz;
    endfunction

    // Stage s1..s3: bring scan_clk into the clock domain; tick marks its rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= scan_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_tick = r_s2 & ~r_s3;

    always_comb begin
        w_state_n    = r_state;
        w_idx_n      = r_idx;
        w_cnt_n      = r_cnt;
        w_snap_val_n = r_snap_val;
        w_snap_dp_n  = r_snap_dp;
        w_frame_n    = 1'b0;
        if (!enable) begin
            w_state_n = S_OFF;
            w_idx_n   = '0;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_n    = S_BLANK;
                    w_idx_n      = '0;
                    w_cnt_n      = '0;
                    w_snap_val_n = value;
                    w_snap_dp_n  = dp;
                end
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_n = S_SHOW;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + 8'd1;
                    end
                end
                S_SHOW: begin
                    if (w_tick) begin
                        w_state_n = S_BLANK;
                        w_cnt_n   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_n      = '0;
                            w_snap_val_n = value;
                            w_snap_dp_n  = dp;
                            w_frame_n    = 1'b1;
                        end else begin
                            w_idx_n = r_idx + 1'b1;
                        end
                    end
                end
                default: w_state_n = S_OFF;
            endcase
        end

        // Outputs follow the next state so they are registered with it.
        w_an_n   = '1;
        w_seg_n  = 7'h7F;
        w_dp_n_n = 1'b1;
        if (w_state_n == S_SHOW) begin
            w_an_n[w_idx_n] = 1'b0;
            w_seg_n  = (LEADING_ZERO_BLANK && lz_blank(w_snap_val_n, w_idx_n)) ? 7'h7F :
                       hex_decode(w_snap_val_n[{w_idx_n, 2'b00} +: 4]);
            w_dp_n_n = ~w_snap_dp_n[w_idx_n];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_OFF;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_snap_val <= '0;
            r_snap_dp  <= '0;
            r_an       <= '1;
            r_seg      <= 7'h7F;
            r_dp_n     <= 1'b1;
            r_frame    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_cnt      <= w_cnt_n;
            r_snap_val <= w_snap_val_n;
            r_snap_dp  <= w_snap_dp_n;
            r_an       <= w_an_n;
            r_seg      <= w_seg_n;
            r_dp_n     <= w_dp_n_n;
            r_frame    <= w_frame_n;
        end
    end

    assign seg        = r_seg;
    assign dp_n       = r_dp_n;
    assign an         = r_an;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame;
endmodule

// File: tb/tb_seg_scan_mux.sv
`timescale 1ns/1ps
// tb_seg_scan_mux: random scan/value/enable stimulus checked against a frame-level
// display model (snapshot per frame, digit order, blank length, leading zeros).
module tb_seg_scan_mux;
    localparam int D = 4;
    localparam int B = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scan_clk;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [6:0]  seg, seg_b;
    logic        dp_n, dp_n_b;
    logic [3:0]  an, an_b;
    logic [1:0]  digit_idx, idx_b;
    logic        frame_done, fd_b;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_mux #(.DIGITS(D), .BLANK_CYCLES(B), .LEADING_ZERO_BLANK(1'b1)) dut (
        .clock(clock), .reset(reset), .scan_clk(scan_clk), .enable(enable),
        .value(value), .dp(dp), .seg(seg), .dp_n(dp_n), .an(an),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    seg_scan_mux #(.DIGITS(D), .BLANK_CYCLES(B), .LEADING_ZERO_BLANK(1'b0)) dut_nlz (
        .clock(clock), .reset(reset), .scan_clk(scan_clk), .enable(enable),
        .value(value), .dp(dp), .seg(seg_b), .dp_n(dp_n_b), .an(an_b),
        .digit_idx(idx_b), .frame_done(fd_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Scan clock source: free-running with jitter, or held at a level for directed tests.
    int   scan_half = 32;
    bit   scan_auto = 1'b1;
    logic scan_hold = 1'b0;

    initial begin
        scan_clk = 1'b0;
        forever begin
            if (scan_auto) begin
                repeat (scan_half + ((scan_half > 4) ? int'($urandom_range(0, 2)) : 0)) @(posedge clock);
                #($urandom_range(1, 8));
                scan_clk = ~scan_clk;
            end else begin
                @(posedge clock);
                #3;
                scan_clk = scan_hold;
            end
        end
    end

    // Reference model, evaluated between edges from the inputs present at the last edge.
    logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    bit          m_on = 1'b0;
    bit          in_show = 1'b0;
    bit          exp_fd;
    int          m_idx = 0;
    int          dark_run = 0;
    logic [15:0] snap = '0;
    logic [15:0] val_p = '0;
    logic [3:0]  sdp = '0;
    logic [3:0]  dp_p = '0;
    logic        rst_p = 1'b0;
    logic        en_p = 1'b0;
    logic [3:0]  exp_an;
    logic [3:0]  dig;
    logic [6:0]  exp_seg;
    logic        exp_dpn;

    always @(negedge clock) begin
        exp_fd = 1'b0;
        if (!reset || !rst_p || !en_p) begin
            chk("dark_off", {an, seg, dp_n, digit_idx}, {4'hF, 7'h7F, 1'b1, 2'd0});
            chk("dark_off_nlz", {an_b, seg_b, dp_n_b, idx_b}, {4'hF, 7'h7F, 1'b1, 2'd0});
            m_on    = 1'b0;
            m_idx   = 0;
            in_show = 1'b0;
        end else begin
            if (!m_on) begin
                m_on     = 1'b1;
                m_idx    = 0;
                snap     = val_p;
                sdp      = dp_p;
                dark_run = 0;
            end
            if (an != 4'hF) begin
                if (!in_show) chk("blank_len", dark_run, B);
                exp_an        = 4'hF;
                exp_an[m_idx] = 1'b0;
                dig           = 4'(snap >> (4 * m_idx));
                exp_seg       = (m_idx > 0 && (snap >> (4 * m_idx)) == 16'h0) ? 7'h7F : seg_tab[dig];
                exp_dpn       = ~sdp[m_idx];
                chk("an", an, exp_an);
                chk("seg", seg, exp_seg);
                chk("dp_n", dp_n, exp_dpn);
                chk("an_nlz", an_b, exp_an);
                chk("seg_nlz", seg_b, seg_tab[dig]);
                chk("dp_n_nlz", dp_n_b, exp_dpn);
                in_show = 1'b1;
            end else begin
                if (in_show) begin
                    m_idx    = (m_idx + 1) % D;
                    dark_run = 0;
                    if (m_idx == 0) begin
                        snap   = val_p;
                        sdp    = dp_p;
                        exp_fd = 1'b1;
                    end
                end
                dark_run++;
                chk("dark", {seg, dp_n, an_b, seg_b, dp_n_b}, {7'h7F, 1'b1, 4'hF, 7'h7F, 1'b1});
                in_show = 1'b0;
            end
            chk("digit_idx", digit_idx, m_idx);
            chk("digit_idx_nlz", idx_b, m_idx);
        end
        chk("frame_done", frame_done, exp_fd);
        chk("frame_done_nlz", fd_b, exp_fd);
        rst_p = reset;
        en_p  = enable;
        val_p = value;
        dp_p  = dp;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // any_show=1 waits for any lit anode, otherwise for an exact anode pattern.
    task automatic wait_an(input logic [3:0] tgt, input bit any_show, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(posedge clock);
            #1;
            hit = any_show ? (an != 4'hF) : (an == tgt);
        end
        chk(tag, hit, 1'b1);
        #1;
    endtask

    int edges;
    bit seen;

    initial begin
        enable = 1'b0;
        value  = '0;
        dp     = '0;
        #1 reset = 1'b0;
        repeat (30) @(posedge clock);
        #2 reset = 1'b1;
        wait_cycles(20);

        value = 16'h1234; dp = 4'b0100; enable = 1'b1;
        wait_cycles(700);
        value = 16'h0050; dp = 4'b0000;
        wait_cycles(700);
        value = 16'h1234; dp = 4'b0100;
        wait_cycles(400);
        wait_an(4'b1011, 1'b0, "wait_digit2_snap");
        value = 16'hABCD;
        wait_cycles(700);
        wait_an(4'b1011, 1'b0, "wait_digit2_en");
        enable = 1'b0;
        wait_cycles(20);
        enable = 1'b1;
        wait_cycles(400);

        for (int i = 0; i < 20; i++) begin
            value = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp    = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                wait_cycles($urandom_range(1, 30));
                enable = 1'b1;
            end
            wait_cycles($urandom_range(100, 500));
        end

        scan_half = 3;
        wait_cycles(600);
        scan_half = 32;
        wait_cycles(300);

        scan_auto = 1'b0;
        scan_hold = 1'b0;
        wait_cycles(80);
        wait_an(4'h0, 1'b1, "wait_show_latency");
        scan_hold = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            seen = scan_clk;
        end
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            edges++;
            #1;
            if (an == 4'hF) break;
        end
        chk("tick_latency", edges, 3);
        scan_hold = 1'b0;
        wait_cycles(10);
        scan_auto = 1'b1;
        wait_cycles(300);

        wait_an(4'h0, 1'b1, "wait_show_reset");
        #1 reset = 1'b0;
        #1 chk("async_reset", {an, seg, dp_n}, {4'hF, 7'h7F, 1'b1});
        wait_cycles(5);
        reset = 1'b1;
        wait_cycles(400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
